// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and default timing.
package sw_debounce_pkg;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch pin and conditioned outputs; sw_toggle exists only with SW_DEBOUNCE_TOGGLE_EN.
interface switch_debounce_if;

  logic sw_raw;
  logic sw_level;
  logic rise_pulse;
  logic fall_pulse;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic sw_toggle;

  modport master (output sw_raw, input sw_level, input rise_pulse, input fall_pulse, input sw_toggle);
  modport slave  (input sw_raw, output sw_level, output rise_pulse, output fall_pulse, output sw_toggle);
`else
  modport master (output sw_raw, input sw_level, input rise_pulse, input fall_pulse);
  modport slave  (input sw_raw, output sw_level, output rise_pulse, output fall_pulse);
`endif

endinterface

// File: rtl/switch_debounce_sync_ff.sv
// Multi-flop synchroniser for an asynchronous input pin; reusable for any async pin.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Switch conditioning: synchroniser, bounce filter FSM, level and edge strobes.
// Optional SW_DEBOUNCE_TOGGLE_EN adds sw_toggle, flipping after each rise_pulse.
module switch_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  switch_debounce_if.slave sw
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sw_s;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw.sw_raw),
    .q   (sw_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOW;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        S_LOW: begin
          if (sw_s) begin
            state <= S_RISE_WAIT;
            cnt   <= '0;
          end
        end
        S_RISE_WAIT: begin
          if (!sw_s) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_HIGH;
            cnt     <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!sw_s) begin
            state <= S_FALL_WAIT;
            cnt   <= '0;
          end
        end
        S_FALL_WAIT: begin
          if (sw_s) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_LOW;
            cnt     <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign sw.sw_level   = level_q;
  assign sw.rise_pulse = rise_q;
  assign sw.fall_pulse = fall_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= 1'b0;
    end else if (rise_q) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign sw.sw_toggle = toggle_q;
`endif

endmodule
